hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- Sits in the EXE stage, directly upstream of the 1-cycle registered 32x32 multiplier (`multipler`).
- Accepts MULT/MULTU/MTHI/MTLO/MFHI/MFLO operations through a valid/ready handshake.
- Registers the multiplier operands and tracks the in-flight product.
- Writes the 64-bit product into the architectural HI/LO registers; returns MFHI/MFLO data to the pipeline.
- Stalls the pipeline (op_ready low) while a product is in flight.

Parameters:
- None. Data width fixed at 32 (HI/LO) / 64 (product) to match the multiplier.

Ports:
- mul_clk  in  1  single clock, shared with the multiplier
- resetn  in  1  asynchronous, active-low reset
- op_valid  in  1  EXE-stage HI/LO operation present
- op_ready  out  1  unit can accept an operation this cycle
- op_type  in  3  0 MULT, 1 MULTU, 2 MTHI, 3 MTLO, 4 MFHI, 5 MFLO, 6-7 reserved
- op_rs  in  32  multiplicand / MTHI-MTLO source data
- op_rt  in  32  multiplier operand
- flush  in  1  exception/eret flush; cancels the in-flight op
- mul_signed  out  1  to multiplier, registered
- mul_x  out  32  to multiplier, registered
- mul_y  out  32  to multiplier, registered
- mul_result  in  64  from multiplier; upper 32 -> HI, lower 32 -> LO
- mf_valid  out  1  one-cycle pulse, MFHI/MFLO data valid
- mf_data  out  32  MFHI/MFLO result
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  product in flight (state != IDLE)

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - hi, lo, mul_x, mul_y, mf_data = 0.
  - mul_signed, mf_valid = 0.
  - Takes effect immediately, including mid-operation; any in-flight product is discarded.
- Accept: accept = op_valid & op_ready & ~flush, with op_ready = (state==IDLE).
- Priority: flush beats op_valid in the same cycle. The op is not accepted and nothing changes.
- States: IDLE, ISSUE, CAPTURE.
- IDLE, accept with MULT/MULTU:
  - At edge E0: mul_x<=op_rs, mul_y<=op_rt.
  - mul_signed<=1 for MULT, 0 for MULTU.
  - Next state ISSUE.
- ISSUE: the multiplier samples mul_x/mul_y at edge E1. Next state CAPTURE.
- CAPTURE: mul_result is valid. At edge E2: hi<=mul_result[63:32], lo<=mul_result[31:0]; next state IDLE.
- Latency: HI/LO update 2 edges after accept; op_ready is low for exactly 2 cycles.
- Flush in ISSUE or CAPTURE: next state IDLE, hi/lo not written.
- mul_x/mul_y/mul_signed hold their last values after completion or flush; they are not cleared.
- MTHI/MTLO (IDLE, single cycle): hi<=op_rs or lo<=op_rs at the accept edge; state stays IDLE.
- MFHI/MFLO (IDLE):
  - At the accept edge: mf_valid<=1, mf_data<=hi or lo as it stood before that edge.
  - mf_valid returns to 0 on the next edge unless another MF is accepted.
  - Back-to-back MF ops give a continuous mf_valid.
- mf_valid is 0 in every cycle that does not follow an accepted MF op.
- Reserved op_type (6, 7): accepted, no state change, no mf_valid.
- Hazard handling: MFHI/MFLO issued after a MULT stall via op_ready until CAPTURE completes. No forwarding from mul_result.
- After reset release, the multiplier output is forced 0 for one cycle; this is harmless because state is IDLE.

Test Plan:
- MULT op_rs=0xFFFFFFFF, op_rt=0x00000002 -> op_ready low 2 cycles; at E2 hi=0xFFFFFFFF, lo=0xFFFFFFFE; mul_signed=1.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE; mul_signed=0.
- MTHI 0x12345678, then MFHI next cycle -> mf_valid pulses 1 cycle with mf_data=0x12345678. MTLO 0xCAFEF00D, then MFLO -> mf_data=0xCAFEF00D.
- MULT 7x6 immediately followed by MFLO held valid -> MFLO accepted only on the cycle after CAPTURE; mf_data=0x0000002A.
- Preload hi=lo=0x11111111; MULT 3x3; assert flush during ISSUE (repeat with flush during CAPTURE) -> hi/lo stay 0x11111111; op_ready high on the next cycle.
- Preload hi=0xAAAAAAAA; MULT 5x5; drop resetn during CAPTURE -> hi=lo=0 immediately, state IDLE, busy=0, mf_valid=0. Also: flush and op_valid (MTHI) in the same cycle -> hi unchanged.

Source files
------------

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register unit feeding a 1-cycle registered 32x32 multiplier
module hilo_unit (
    input  logic        mul_clk,
    input  logic        resetn,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_type,
    input  logic [31:0] op_rs,
    input  logic [31:0] op_rt,
    input  logic        flush,
    output logic        mul_signed,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_result,
    output logic        mf_valid,
    output logic [31:0] mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd2;
    localparam logic [2:0] OP_MTLO  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mul_x_q, mul_y_q;
    logic        mul_signed_q;
    logic        mf_valid_q, mf_valid_d;
    logic [31:0] mf_data_q, mf_data_d;

    logic accept;
    logic is_mul;
    logic is_mf;

    // Accept only from IDLE; flush wins over a simultaneous request
    always_comb begin
        accept = op_valid & (state_q == ST_IDLE) & ~flush;
        is_mul = (op_type == OP_MULT) | (op_type == OP_MULTU);
        is_mf  = (op_type == OP_MFHI) | (op_type == OP_MFLO);
    end

    // Sequencer: IDLE -> ISSUE (multiplier samples) -> CAPTURE (product lands) -> IDLE
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && is_mul) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= flush ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand registers: loaded on a MULT/MULTU accept, otherwise held
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            mul_x_q      <= 32'd0;
            mul_y_q      <= 32'd0;
            mul_signed_q <= 1'b0;
        end else if (accept && is_mul) begin
            mul_x_q      <= op_rs;
            mul_y_q      <= op_rt;
            mul_signed_q <= (op_type == OP_MULT);
        end
    end

    // HI/LO next value: product in CAPTURE unless flushed, or a move-to op from IDLE
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == ST_CAPTURE) begin
            if (!flush) begin
                hi_d = mul_result[63:32];
                lo_d = mul_result[31:0];
            end
        end else if (accept) begin
            if (op_type == OP_MTHI) begin
                hi_d = op_rs;
            end
            if (op_type == OP_MTLO) begin
                lo_d = op_rs;
            end
        end
    end

    // Architectural HI/LO
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Move-from result: reads HI/LO as they stood before the accept edge
    always_comb begin
        mf_valid_d = accept & is_mf;
        mf_data_d  = mf_data_q;
        if (mf_valid_d) begin
            mf_data_d = (op_type == OP_MFHI) ? hi_q : lo_q;
        end
    end

    // Move-from output registers; valid is a pulse per accepted MF op
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            mf_valid_q <= 1'b0;
            mf_data_q  <= 32'd0;
        end else begin
            mf_valid_q <= mf_valid_d;
            mf_data_q  <= mf_data_d;
        end
    end

    // Output mapping
    always_comb begin
        op_ready   = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        mul_signed = mul_signed_q;
        mul_x      = mul_x_q;
        mul_y      = mul_y_q;
        mf_valid   = mf_valid_q;
        mf_data    = mf_data_q;
        hi         = hi_q;
        lo         = lo_q;
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit
module tb_hilo_unit;

    logic        mul_clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_type;
    logic [31:0] op_rs;
    logic [31:0] op_rt;
    logic        flush;
    logic        mul_signed;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic [63:0] mul_result;
    logic        mf_valid;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always #5 mul_clk = ~mul_clk;

    hilo_unit dut (
        .mul_clk    (mul_clk),
        .resetn     (resetn),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_type    (op_type),
        .op_rs      (op_rs),
        .op_rt      (op_rt),
        .flush      (flush),
        .mul_signed (mul_signed),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_result (mul_result),
        .mf_valid   (mf_valid),
        .mf_data    (mf_data),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy)
    );

    logic signed [63:0] sx, sy;
    always_comb begin
        sx = {{32{mul_x[31]}}, mul_x};
        sy = {{32{mul_y[31]}}, mul_y};
    end
    always @(posedge mul_clk or negedge resetn) begin
        if (!resetn)
            mul_result <= 64'd0;
        else if (mul_signed)
            mul_result <= sx * sy;
        else
            mul_result <= {32'd0, mul_x} * {32'd0, mul_y};
    end

    task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt);
        op_valid = v;
        op_type  = t;
        op_rs    = rs;
        op_rt    = rt;
    endtask

    initial begin
        resetn = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(negedge mul_clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_mul_x", mul_x, 32'd0);
        chk("rst_mul_y", mul_y, 32'd0);
        chk("rst_mf_data", mf_data, 32'd0);
        chk("rst_mf_valid", mf_valid, 1'b0);
        chk("rst_mul_signed", mul_signed, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", op_ready, 1'b1);
        resetn = 1'b1;
        @(negedge mul_clk);

        drive(1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000002);
        @(negedge mul_clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk("mult_ready_c1", op_ready, 1'b0);
        chk("mult_busy_c1", busy, 1'b1);
        chk("mult_signed", mul_signed, 1'b1);
        chk("mult_x", mul_x, 32'hFFFFFFFF);
        chk("mult_y", mul_y, 32'h00000002);
        @(negedge mul_clk);
        chk("mult_ready_c2", op_ready, 1'b0);
        chk("mult_hi_c2", hi, 32'd0);
        @(negedge mul_clk);
        chk("mult_ready_c3", op_ready, 1'b1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);

        drive(1'b1, 3'd1, 32'hFFFFFFFF, 32'h00000002);
        @(negedge mul_clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk("multu_signed", mul_signed, 1'b0);
        repeat (2) @(negedge mul_clk);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);
        chk("multu_x_hold", mul_x, 32'hFFFFFFFF);

        drive(1'b1, 3'd2, 32'h12345678, 32'd0);
        @(negedge mul_clk);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_no_mf", mf_valid, 1'b0);
        drive(1'b1, 3'd4, 32'd0, 32'd0);
        @(negedge mul_clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk("mfhi_valid", mf_valid, 1'b1);
        chk("mfhi_data", mf_data, 32'h12345678);
        @(negedge mul_clk);
        chk("mfhi_pulse_end", mf_valid, 1'b0);
        drive(1'b1, 3'd3, 32'hCAFEF00D, 32'd0);
        @(negedge mul_clk);
        chk("mtlo_lo", lo, 32'hCAFEF00D);
        chk("mtlo_hi_kept", hi, 32'h12345678);
        drive(1'b1, 3'd5, 32'd0, 32'd0);
        @(negedge mul_clk);
        chk("mflo_valid", mf_valid, 1'b1);
        chk("mflo_data", mf_data, 32'hCAFEF00D);
        drive(1'b1, 3'd4, 32'd0, 32'd0);
        @(negedge mul_clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk("b2b_mf_valid", mf_valid, 1'b1);
        chk("b2b_mf_data", mf_data, 32'h12345678);
        @(negedge mul_clk);
        chk("b2b_mf_end", mf_valid, 1'b0);

        drive(1'b1, 3'd0, 32'd7, 32'd6);
        @(negedge mul_clk);
        drive(1'b1, 3'd5, 32'd0, 32'd0);
        @(negedge mul_clk);
        chk("haz_stall1_mf", mf_valid, 1'b0);
        @(negedge mul_clk);
        chk("haz_stall2_mf", mf_valid, 1'b0);
        chk("haz_lo", lo, 32'h0000002A);
        chk("haz_ready", op_ready, 1'b1);
        @(negedge mul_clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk("haz_mf_valid", mf_valid, 1'b1);
        chk("haz_mf_data", mf_data, 32'h0000002A);
        @(negedge mul_clk);
        chk("haz_mf_end", mf_valid, 1'b0);

        drive(1'b1, 3'd2, 32'h11111111, 32'd0);
        @(negedge mul_clk);
        drive(1'b1, 3'd3, 32'h11111111, 32'd0);
        @(negedge mul_clk);
        drive(1'b1, 3'd0, 32'd3, 32'd3);
        @(negedge mul_clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        flush = 1'b1;
        @(negedge mul_clk);
        flush = 1'b0;
        chk("fl_iss_ready", op_ready, 1'b1);
        chk("fl_iss_busy", busy, 1'b0);
        @(negedge mul_clk);
        chk("fl_iss_hi", hi, 32'h11111111);
        chk("fl_iss_lo", lo, 32'h11111111);

        drive(1'b1, 3'd0, 32'd3, 32'd3);
        @(negedge mul_clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge mul_clk);
        flush = 1'b1;
        @(negedge mul_clk);
        flush = 1'b0;
        chk("fl_cap_ready", op_ready, 1'b1);
        chk("fl_cap_hi", hi, 32'h11111111);
        chk("fl_cap_lo", lo, 32'h11111111);
        chk("fl_cap_x_hold", mul_x, 32'd3);

        drive(1'b1, 3'd2, 32'hAAAAAAAA, 32'd0);
        @(negedge mul_clk);
        drive(1'b1, 3'd0, 32'd5, 32'd5);
        @(negedge mul_clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge mul_clk);
        chk("rstcap_busy_before", busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rstcap_hi", hi, 32'd0);
        chk("rstcap_lo", lo, 32'd0);
        chk("rstcap_busy", busy, 1'b0);
        chk("rstcap_mf_valid", mf_valid, 1'b0);
        chk("rstcap_ready", op_ready, 1'b1);
        @(negedge mul_clk);
        chk("rstcap_hi_after_edge", hi, 32'd0);
        resetn = 1'b1;
        @(negedge mul_clk);

        flush = 1'b1;
        drive(1'b1, 3'd2, 32'hDEADBEEF, 32'd0);
        @(negedge mul_clk);
        chk("fl_mthi_hi", hi, 32'd0);
        drive(1'b1, 3'd4, 32'd0, 32'd0);
        @(negedge mul_clk);
        chk("fl_mfhi_valid", mf_valid, 1'b0);
        drive(1'b1, 3'd0, 32'd9, 32'd9);
        @(negedge mul_clk);
        chk("fl_mult_busy", busy, 1'b0);
        flush = 1'b0;

        drive(1'b1, 3'd6, 32'h5A5A5A5A, 32'd1);
        @(negedge mul_clk);
        drive(1'b1, 3'd7, 32'h5A5A5A5A, 32'd1);
        @(negedge mul_clk);
        chk("rsv_ready", op_ready, 1'b1);
        chk("rsv_mf", mf_valid, 1'b0);
        chk("rsv_hi", hi, 32'd0);
        chk("rsv_lo", lo, 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge mul_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
